// File: rtl/mem_access_unit.sv
// MEM-stage load/store initiator: word/byte loads and stores against a registered data memory.
// Optional byte loads and read-modify-write byte stores are enabled by defining MEM_ACCESS_BYTE_EN.
module mem_access_unit #(
    parameter int unsigned MEM_WORDS = 128
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        is_store,
    input  logic        byte_op,
    input  logic        sign_ext,
    input  logic [9:0]  addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] rdata,
    output logic        fault,
    output logic        memRead,
    output logic        memWrite,
    output logic [7:0]  memaddress,
    output logic [31:0] invalue,
    output logic [2:0]  stage,
    input  logic [31:0] outvalue
);

    typedef enum logic [2:0] {S_IDLE, S_RD, S_CAP, S_WR, S_DONE} state_t;

    state_t      r_state, w_next;
    logic        r_store, r_fault;
    logic [7:0]  r_waddr;
    logic [31:0] r_wdata, r_rdata;
    logic        w_byte, w_fault, w_accept;
    logic [31:0] w_load_val, w_wr_data;

`ifdef MEM_ACCESS_BYTE_EN
    logic        r_byte, r_sext;
    logic [1:0]  r_lane;
    logic [31:0] r_merge, w_merged;
    logic [7:0]  w_lane_byte;

    assign w_byte = byte_op;

    // Little-endian lanes: lane 0 is bits [7:0].
    always_comb begin
        w_lane_byte = outvalue[7:0];
        w_merged    = outvalue;
        case (r_lane)
            2'd0: begin w_lane_byte = outvalue[7:0];   w_merged[7:0]   = r_wdata[7:0]; end
            2'd1: begin w_lane_byte = outvalue[15:8];  w_merged[15:8]  = r_wdata[7:0]; end
            2'd2: begin w_lane_byte = outvalue[23:16]; w_merged[23:16] = r_wdata[7:0]; end
            default: begin w_lane_byte = outvalue[31:24]; w_merged[31:24] = r_wdata[7:0]; end
        endcase
    end

    assign w_load_val = !r_byte ? outvalue :
                        r_sext  ? {{24{w_lane_byte[7]}}, w_lane_byte} : {24'd0, w_lane_byte};
    assign w_wr_data  = r_byte ? r_merge : r_wdata;
`else
    logic w_unused;
    assign w_unused   = ^{byte_op, sign_ext};
    assign w_byte     = 1'b0;
    assign w_load_val = outvalue;
    assign w_wr_data  = r_wdata;
`endif

    assign w_accept = (r_state == S_IDLE) && start;
    assign w_fault  = (!w_byte && (addr[1:0] != 2'd0)) || ({24'd0, addr[9:2]} >= MEM_WORDS);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    if (w_fault)                 w_next = S_DONE;
                    else if (is_store && !w_byte) w_next = S_WR;
                    else                          w_next = S_RD;
                end
            end
            S_RD:  w_next = S_CAP;
`ifdef MEM_ACCESS_BYTE_EN
            S_CAP: w_next = r_store ? S_WR : S_DONE;
`else
            S_CAP: w_next = S_DONE;
`endif
            S_WR:   w_next = S_DONE;
            S_DONE: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_store <= 1'b0;
            r_fault <= 1'b0;
            r_waddr <= 8'd0;
            r_wdata <= 32'd0;
            r_rdata <= 32'd0;
`ifdef MEM_ACCESS_BYTE_EN
            r_byte  <= 1'b0;
            r_sext  <= 1'b0;
            r_lane  <= 2'd0;
            r_merge <= 32'd0;
`endif
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_store <= is_store;
                r_fault <= w_fault;
                r_waddr <= addr[9:2];
                r_wdata <= wdata;
`ifdef MEM_ACCESS_BYTE_EN
                r_byte  <= byte_op;
                r_sext  <= sign_ext;
                r_lane  <= addr[1:0];
`endif
            end
            if (r_state == S_CAP && !r_store) r_rdata <= w_load_val;
`ifdef MEM_ACCESS_BYTE_EN
            if (r_state == S_CAP && r_store)  r_merge <= w_merged;
`endif
        end
    end

    // Strobes are gated by reset so a reset edge never performs an access.
    assign busy       = (r_state != S_IDLE);
    assign done       = (r_state == S_DONE);
    assign fault      = (r_state == S_DONE) && r_fault;
    assign rdata      = r_rdata;
    assign memRead    = (r_state == S_RD) && !reset;
    assign memWrite   = (r_state == S_WR) && !reset;
    assign memaddress = r_waddr;
    assign invalue    = (r_state == S_WR) ? w_wr_data : 32'd0;
    assign stage      = (r_state == S_RD || r_state == S_WR) ? 3'd3 : 3'd0;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit with a registered data-memory model.
module tb_mem_access_unit;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0, is_store = 1'b0, byte_op = 1'b0, sign_ext = 1'b0;
    logic [9:0]  addr = 10'd0;
    logic [31:0] wdata = 32'd0;
    logic        busy, done, fault, memRead, memWrite;
    logic [31:0] rdata, invalue;
    logic [31:0] outvalue = 32'd0;
    logic [7:0]  memaddress;
    logic [2:0]  stage;

    mem_access_unit #(.MEM_WORDS(128)) dut (
        .clock(clock), .reset(reset), .start(start), .is_store(is_store),
        .byte_op(byte_op), .sign_ext(sign_ext), .addr(addr), .wdata(wdata),
        .busy(busy), .done(done), .rdata(rdata), .fault(fault),
        .memRead(memRead), .memWrite(memWrite), .memaddress(memaddress),
        .invalue(invalue), .stage(stage), .outvalue(outvalue)
    );

    always #5 clock = ~clock;

    logic [31:0] mem [0:255];
    logic        mem_clr = 1'b1;
    always @(posedge clock) begin
        if (mem_clr) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'd0;
        end else begin
            if (memWrite) mem[memaddress] <= invalue;
            if (memRead)  outvalue <= mem[memaddress];
        end
    end

    typedef struct {
        int          k;
        logic [31:0] rd;
        logic        f;
        int          lat;
        logic        acc;
        logic [7:0]  wa;
    } exp_t;

    exp_t        q[$];
    int          total = 0, bad = 0, cyc = 0;
    logic        strobe_seen = 1'b0;
    logic [31:0] last_rd = 32'd0;

    always @(posedge clock) cyc++;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s got=%h want=%h", n, act, req);
        end
    endtask

    // Monitor: pops expected completion whenever done is presented.
    always @(negedge clock) begin
        exp_t e;
        if (reset) begin
            q.delete();
            strobe_seen = 1'b0;
        end else begin
            if (memRead || memWrite) begin
                strobe_seen = 1'b1;
                if (memRead && memWrite) chk("strobe_excl", 32'd1, 32'd0);
                if (q.size() > 0) chk("waddr", {24'd0, memaddress}, {24'd0, q[0].wa});
                chk("stage", {29'd0, stage}, 32'd3);
            end
            if (done) begin
                if (q.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = q.pop_front();
                    chk("fault", {31'd0, fault}, {31'd0, e.f});
                    chk("rdata", rdata, e.rd);
                    chk("latency", cyc - e.k, e.lat);
                    chk("mem_access", {31'd0, strobe_seen}, {31'd0, e.acc});
                    strobe_seen = 1'b0;
                end
            end
        end
    end

    task automatic wait_done();
        for (int i = 0; i < 20 && q.size() != 0; i++) begin
            @(negedge clock); #1;
        end
        if (q.size() != 0) begin
            chk("timeout", q.size(), 0);
            q.delete();
        end
    endtask

    task automatic op(input logic st, input logic by, input logic sx, input logic [9:0] a,
                      input logic [31:0] wd, input logic [31:0] ld, input logic f, input int lat);
        logic [31:0] er;
        er = (!st && !f) ? ld : last_rd;
        last_rd = er;
        @(negedge clock);
        start = 1'b1; is_store = st; byte_op = by; sign_ext = sx; addr = a; wdata = wd;
        q.push_back('{cyc, er, f, lat, !f, a[9:2]});
        @(negedge clock);
        start = 1'b0;
        #1;
        wait_done();
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_busy"},  {31'd0, busy},     32'd0);
        chk({tag, "_done"},  {31'd0, done},     32'd0);
        chk({tag, "_rdata"}, rdata,             32'd0);
        chk({tag, "_fault"}, {31'd0, fault},    32'd0);
        chk({tag, "_mrd"},   {31'd0, memRead},  32'd0);
        chk({tag, "_mwr"},   {31'd0, memWrite}, 32'd0);
        chk({tag, "_maddr"}, {24'd0, memaddress}, 32'd0);
        chk({tag, "_inval"}, invalue,           32'd0);
        chk({tag, "_stage"}, {29'd0, stage},    32'd0);
    endtask

    initial begin
        repeat (3) @(negedge clock);
        chk_reset_outputs("rst");
        reset = 1'b0; mem_clr = 1'b0;

        // Word store then load-back.
        op(1, 0, 0, 10'h010, 32'hDEADBEEF, 0, 0, 2);
        chk("mem4_store", mem[4], 32'hDEADBEEF);
        op(0, 0, 0, 10'h010, 0, 32'hDEADBEEF, 0, 3);
        // Misaligned and out-of-range faults.
        op(0, 0, 0, 10'h012, 0, 0, 1, 1);
        op(0, 0, 0, 10'h200, 0, 0, 1, 1);
        op(1, 0, 0, 10'h013, 32'h0BADF00D, 0, 1, 1);
        chk("mem4_nofault_wr", mem[4], 32'hDEADBEEF);
        // Last valid word.
        op(1, 0, 0, 10'h1FC, 32'h12345678, 0, 0, 2);
        op(0, 0, 0, 10'h1FC, 0, 32'h12345678, 0, 3);

`ifdef MEM_ACCESS_BYTE_EN
        op(1, 0, 0, 10'h010, 32'h11223344, 0, 0, 2);
        op(1, 1, 0, 10'h012, 32'h000000AB, 0, 0, 4);
        chk("mem4_rmw", mem[4], 32'h11AB3344);
        op(0, 1, 1, 10'h012, 0, 32'hFFFFFFAB, 0, 3);
        op(0, 1, 0, 10'h012, 0, 32'h000000AB, 0, 3);
        op(0, 1, 1, 10'h010, 0, 32'h00000044, 0, 3);
        op(0, 1, 1, 10'h013, 0, 32'h00000011, 0, 3);
        op(0, 1, 0, 10'h201, 0, 0, 1, 1);
`else
        op(1, 0, 0, 10'h010, 32'h11223344, 0, 0, 2);
        op(0, 1, 1, 10'h010, 0, 32'h11223344, 0, 3);
        op(1, 1, 0, 10'h012, 32'h000000AB, 0, 1, 1);
        chk("mem4_byte_ignored", mem[4], 32'h11223344);
`endif

        // Second start during RD must be ignored.
        @(negedge clock);
        start = 1'b1; is_store = 1'b0; byte_op = 1'b0; addr = 10'h010; wdata = 32'd0;
        q.push_back('{cyc, mem[4], 1'b0, 3, 1'b1, 8'd4});
        last_rd = mem[4];
        @(negedge clock);
        is_store = 1'b1; addr = 10'h020; wdata = 32'hCAFEF00D;
        @(negedge clock);
        start = 1'b0;
        #1;
        wait_done();
        chk("mem8_repulse", mem[8], 32'd0);

        // Reset mid-operation.
        @(negedge clock);
`ifdef MEM_ACCESS_BYTE_EN
        start = 1'b1; is_store = 1'b1; byte_op = 1'b1; addr = 10'h011; wdata = 32'h55;
        @(negedge clock);
        start = 1'b0;
        @(negedge clock);
`else
        start = 1'b1; is_store = 1'b0; byte_op = 1'b0; addr = 10'h010; wdata = 32'h0;
        @(negedge clock);
        start = 1'b0;
`endif
        reset = 1'b1;
        #1;
        chk("rst_mid_mrd", {31'd0, memRead},  32'd0);
        chk("rst_mid_mwr", {31'd0, memWrite}, 32'd0);
        @(negedge clock); #1;
        chk_reset_outputs("rst_mid");
        @(negedge clock);
        reset = 1'b0;
`ifdef MEM_ACCESS_BYTE_EN
        chk("mem4_rst", mem[4], 32'h11AB3344);
`else
        chk("mem4_rst", mem[4], 32'h11223344);
`endif
        last_rd = 32'd0;
        op(0, 0, 0, 10'h1FC, 0, 32'h12345678, 0, 3);

        repeat (2) @(negedge clock);
        chk("queue_empty", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
